bus_cycle_controller: RTL



---
 rtl/bus_ctrl_pkg.sv | 46 ++++
 rtl/bus_input_sync.sv | 24 ++
 rtl/bus_cycle_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_ctrl_pkg.sv
// rtl/bus_ctrl_pkg.sv - shared types and constants for the 68000 bus cycle controller
package bus_ctrl_pkg;

    typedef enum logic [2:0] {
        ROM,
        RAM,
        DUART,
        IO,
        UNMAPPED
    } region_t;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ACK,
        AVEC,
        FAULT,
        HOLD
    } state_t;

    localparam logic [3:0] ROM_BASE   = 4'h0;
    localparam logic [3:0] RAM_BASE   = 4'h8;
    localparam logic [3:0] DUART_BASE = 4'hC;
    localparam logic [3:0] IO_BASE    = 4'hF;

    localparam logic [2:0] FC_IACK = 3'b111;

    // The boot overlay maps the whole address space onto ROM so the reset
    // vector fetch at 0x000000/0x000004 and early code always hit the ROM.
    function automatic region_t decode_region(input logic [3:0] addr_h, input logic boot);
        region_t r;
        if (boot) begin
            r = ROM;
        end else begin
            case (addr_h)
                ROM_BASE:   r = ROM;
                RAM_BASE:   r = RAM;
                DUART_BASE: r = DUART;
                IO_BASE:    r = IO;
                default:    r = UNMAPPED;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_input_sync.sv
// rtl/bus_input_sync.sv - parameterised-width two-flop synchronizer, resets to all-ones
module bus_input_sync #(
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two register stages; all-ones reset keeps the active-low strobes idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bus_cycle_controller.sv
// rtl/bus_cycle_controller.sv - 68000 bus cycle sequencer (DTACK/BERR/VPA/BOOT); optional watchdog via BUS_TIMEOUT_EN
module bus_cycle_controller
    import bus_ctrl_pkg::*;
#(
    parameter int ROM_WS         = 2,
    parameter int RAM_WS         = 0,
    parameter int DUART_WS       = 4,
    parameter int IO_WS          = 1,
    parameter int BOOT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       AS,
    input  logic       UDS,
    input  logic       LDS,
    input  logic       RW,
    input  logic [2:0] FC,
    input  logic [3:0] ADDR_H,
    output logic       DTACK,
    output logic       BERR,
    output logic       VPA,
    output logic       BOOT
);

    // Wait counter is 4 bits, boot counter 3 bits, watchdog 8 bits.
    if (ROM_WS > 15 || RAM_WS > 15 || DUART_WS > 15 || IO_WS > 15) begin : g_ws_range
        $error("bus_cycle_controller: wait-state parameter exceeds 15");
    end
    if (BOOT_CYCLES < 1 || BOOT_CYCLES > 7) begin : g_boot_range
        $error("bus_cycle_controller: BOOT_CYCLES must be 1..7");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_to_range
        $error("bus_cycle_controller: TIMEOUT_CYCLES must be 2..256");
    end

    logic [2:0] sync_q;
    logic       as_s, uds_s, lds_s;

    bus_input_sync #(.WIDTH(3)) u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   ({AS, UDS, LDS}),
        .q   (sync_q)
    );

    assign as_s  = sync_q[2];
    assign uds_s = sync_q[1];
    assign lds_s = sync_q[0];

    function automatic logic [3:0] region_ws(input region_t r);
        case (r)
            ROM:     return 4'(ROM_WS);
            RAM:     return 4'(RAM_WS);
            DUART:   return 4'(DUART_WS);
            IO:      return 4'(IO_WS);
            default: return 4'd0;
        endcase
    endfunction

    state_t     state;
    region_t    region_q;
    region_t    cur_region;
    logic [3:0] wait_cnt;
    logic [2:0] boot_cnt;
    logic       cycle_done;

    assign cur_region = decode_region(ADDR_H, BOOT);
    assign cycle_done = as_s && (state == ACK || state == AVEC);

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wdog;
    logic       dtack_pend;
    logic       unused_ok;
    assign unused_ok = RW;
`else
    logic unused_ok;
    assign unused_ok = ^{RW, region_q};
    assign BERR = 1'b1;
`endif

    // Bus cycle FSM with registered strobes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            DTACK    <= 1'b1;
            VPA      <= 1'b1;
            wait_cnt <= 4'd0;
            region_q <= ROM;
`ifdef BUS_TIMEOUT_EN
            BERR       <= 1'b1;
            wdog       <= 8'd0;
            dtack_pend <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef BUS_TIMEOUT_EN
                    wdog <= 8'd0;
`endif
                    if (!as_s && FC == FC_IACK) begin
                        state <= AVEC;
                        VPA   <= 1'b0;
                    end else if (!as_s && (!uds_s || !lds_s)) begin
                        region_q <= cur_region;
                        wait_cnt <= region_ws(cur_region);
                        state    <= WAIT;
                    end
`ifdef BUS_TIMEOUT_EN
                    // Address strobe with no data strobe: RMW gap, or a stuck bus.
                    else if (!as_s) begin
                        if (wdog == WDOG_LAST) begin
                            state      <= FAULT;
                            BERR       <= 1'b0;
                            dtack_pend <= 1'b0;
                        end else begin
                            wdog <= wdog + 8'd1;
                        end
                    end
`endif
                end
                WAIT: begin
`ifdef BUS_TIMEOUT_EN
                    if (wdog == WDOG_LAST) begin
                        state      <= FAULT;
                        BERR       <= 1'b0;
                        dtack_pend <= 1'b1;
                    end else begin
                        wdog <= wdog + 8'd1;
                        if (wait_cnt != 4'd0) begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end else if (region_q != UNMAPPED) begin
                            state <= ACK;
                            DTACK <= 1'b0;
                        end
                    end
`else
                    if (wait_cnt == 4'd0) begin
                        state <= ACK;
                        DTACK <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
`endif
                end
                ACK: begin
                    if (as_s) begin
                        DTACK <= 1'b1;
                        state <= IDLE;
                    end
                end
                AVEC: begin
`ifdef BUS_TIMEOUT_EN
                    if (wdog == WDOG_LAST && !as_s) begin
                        state      <= FAULT;
                        VPA        <= 1'b1;
                        BERR       <= 1'b0;
                        dtack_pend <= 1'b0;
                    end else begin
                        wdog <= wdog + 8'd1;
                        if (as_s) begin
                            VPA   <= 1'b1;
                            state <= IDLE;
                        end
                    end
`else
                    if (as_s) begin
                        VPA   <= 1'b1;
                        state <= IDLE;
                    end
`endif
                end
`ifdef BUS_TIMEOUT_EN
                FAULT: begin
                    if (as_s) begin
                        BERR  <= 1'b1;
                        state <= IDLE;
                    end else if (dtack_pend) begin
                        state <= HOLD;
                    end
                end
                // A data cycle was abandoned: DTACK stays high until the CPU ends it.
                HOLD: begin
                    DTACK <= 1'b1;
                    if (as_s) begin
                        BERR       <= 1'b1;
                        dtack_pend <= 1'b0;
                        state      <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Boot overlay: count completed DTACK/VPA cycles, drop BOOT for good at the limit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            BOOT     <= 1'b1;
            boot_cnt <= 3'd0;
        end else if (BOOT && cycle_done) begin
            boot_cnt <= boot_cnt + 3'd1;
            if (boot_cnt == 3'(BOOT_CYCLES - 1)) begin
                BOOT <= 1'b0;
            end
        end
    end

endmodule
